// File: rtl/alu_pkg.sv
// alu_pkg
// Constants shared by the ALU datapath and its register stage:
//   WIDTH    - operand/result width (all signed-overflow rules assume 32)
//   alu_op_t - 4-bit ALUControl encoding; codes 1010-1111 are unused
//              and produce an all-zero result.
package alu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_t;

endpackage

// File: rtl/alu_datapath.sv
// alu_datapath
// Purely combinational ALU core. Produces the next result and status
// flags from the operands and the operation select.
//   ALUControl      : operation select (alu_op_t encoding)
//   a, b            : operands (two's complement where signed)
//   result_next     : operation result
//   zero_next       : result_next == 0
//   overflow_next   : positive signed overflow on ADD/SUB
//   underflow_next  : negative signed overflow on ADD/SUB
//   less_than_next  : signed a < signed b, for every opcode
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH  = alu_pkg::WIDTH,
    parameter int CTRL_W = 4
) (
    input  logic [CTRL_W-1:0] ALUControl,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  result_next,
    output logic              zero_next,
    output logic              overflow_next,
    output logic              underflow_next,
    output logic              less_than_next
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic             slt;
    logic             sltu;
    logic             a_msb;
    logic             b_msb;

    assign sum   = a + b;
    assign diff  = a - b;
    // Only the low bits of b select the shift distance; upper bits ignored.
    assign shamt = b[SHW-1:0];
    assign slt   = $signed(a) < $signed(b);
    assign sltu  = a < b;
    assign a_msb = a[WIDTH-1];
    assign b_msb = b[WIDTH-1];

    always_comb begin
        result_next    = '0;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        case (alu_op_t'(ALUControl))
            ALU_ADD: begin
                result_next    = sum;
                // Both operands share a sign that the sum does not.
                overflow_next  = !a_msb && !b_msb &&  sum[WIDTH-1];
                underflow_next =  a_msb &&  b_msb && !sum[WIDTH-1];
            end
            ALU_SUB: begin
                result_next    = diff;
                // Subtracting flips b's sign, so the operand test mirrors ADD.
                overflow_next  = !a_msb &&  b_msb &&  diff[WIDTH-1];
                underflow_next =  a_msb && !b_msb && !diff[WIDTH-1];
            end
            ALU_AND:  result_next = a & b;
            ALU_OR:   result_next = a | b;
            ALU_XOR:  result_next = a ^ b;
            ALU_SLT:  result_next = {{(WIDTH-1){1'b0}}, slt};
            ALU_SLTU: result_next = {{(WIDTH-1){1'b0}}, sltu};
            ALU_SLL:  result_next = a << shamt;
            ALU_SRL:  result_next = a >> shamt;
            ALU_SRA:  result_next = $unsigned($signed(a) >>> shamt);
            default:  result_next = '0;
        endcase
    end

    assign zero_next      = (result_next == '0);
    assign less_than_next = slt;

endmodule

// File: rtl/riscv_alu.sv
// riscv_alu
// 32-bit RISC-V integer ALU with a registered output stage (one cycle
// of latency, a new operation accepted every cycle).
//   clk            : rising-edge clock
//   reset          : asynchronous, active-high; clears every output
//   ALUControl     : operation select (see alu_pkg::alu_op_t)
//   a, b           : operands
//   result         : registered result
//   zero_flag      : registered, result == 0
//   overflow       : registered, positive signed overflow on ADD/SUB
//   underflow      : registered, negative signed overflow on ADD/SUB
//   less_than_flag : registered, signed a < signed b
module riscv_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = alu_pkg::WIDTH,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ALUControl,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  result,
    output logic              zero_flag,
    output logic              overflow,
    output logic              underflow,
    output logic              less_than_flag
);

    logic [WIDTH-1:0] result_next;
    logic             zero_next;
    logic             overflow_next;
    logic             underflow_next;
    logic             less_than_next;

    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             less_than_reg;

    alu_datapath #(
        .WIDTH  (WIDTH),
        .CTRL_W (CTRL_W)
    ) u_datapath (
        .ALUControl     (ALUControl),
        .a              (a),
        .b              (b),
        .result_next    (result_next),
        .zero_next      (zero_next),
        .overflow_next  (overflow_next),
        .underflow_next (underflow_next),
        .less_than_next (less_than_next)
    );

    // zero_reg clears to 0 under reset even though the cleared result is
    // zero: downstream branch logic must not see a "taken" during reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            less_than_reg <= 1'b0;
        end else begin
            result_reg    <= result_next;
            zero_reg      <= zero_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            less_than_reg <= less_than_next;
        end
    end

    assign result         = result_reg;
    assign zero_flag      = zero_reg;
    assign overflow       = overflow_reg;
    assign underflow      = underflow_reg;
    assign less_than_flag = less_than_reg;

endmodule

// File: tb/tb_riscv_alu.sv
// tb_riscv_alu
// Scoreboard bench for riscv_alu: the driver pushes the expected
// response of every issued operation into a queue; a monitor pops and
// compares one entry after each rising edge. Expected values come from
// an integer-arithmetic reference model.
module tb_riscv_alu;

    logic        clk;
    logic        reset;
    logic [3:0]  ALUControl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero_flag;
    logic        overflow;
    logic        underflow;
    logic        less_than_flag;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        u;
        logic        lt;
    } resp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        resp_t       exp;
    } txn_t;

    txn_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_txn    = 0;

    riscv_alu dut (
        .clk            (clk),
        .reset          (reset),
        .ALUControl     (ALUControl),
        .a              (a),
        .b              (b),
        .result         (result),
        .zero_flag      (zero_flag),
        .overflow       (overflow),
        .underflow      (underflow),
        .less_than_flag (less_than_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: signed results are evaluated exactly in 64 bits and
    // overflow/underflow read off the true value's range; shifts are
    // multiplication / (floor) division by a power of two.
    function automatic resp_t model(input logic [3:0] op, input logic [31:0] x,
                                    input logic [31:0] y);
        resp_t  rsp;
        longint sx;
        longint sy;
        longint ux;
        longint uy;
        longint full;
        longint p;
        longint q;
        int     sh;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        ux   = longint'({32'b0, x});
        uy   = longint'({32'b0, y});
        sh   = int'(y % 32);
        p    = longint'(1) << sh;
        rsp  = '0;
        full = 0;
        case (op)
            4'd0: begin
                full  = sx + sy;
                rsp.r = full[31:0];
                rsp.o = full > 64'sd2147483647;
                rsp.u = full < -64'sd2147483648;
            end
            4'd1: begin
                full  = sx - sy;
                rsp.r = full[31:0];
                rsp.o = full > 64'sd2147483647;
                rsp.u = full < -64'sd2147483648;
            end
            4'd2: rsp.r = x & y;
            4'd3: rsp.r = x | y;
            4'd4: rsp.r = x ^ y;
            4'd5: rsp.r = (sx < sy) ? 32'd1 : 32'd0;
            4'd6: rsp.r = (ux < uy) ? 32'd1 : 32'd0;
            4'd7: begin
                full  = ux * p;
                rsp.r = full[31:0];
            end
            4'd8: begin
                full  = ux / p;
                rsp.r = full[31:0];
            end
            4'd9: begin
                q = sx / p;
                if (sx < 0 && (sx % p) != 0) q = q - 1;
                rsp.r = q[31:0];
            end
            default: rsp.r = 32'd0;
        endcase
        rsp.z  = (rsp.r == 32'd0);
        rsp.lt = sx < sy;
        return rsp;
    endfunction

    function automatic resp_t dut_resp();
        resp_t rsp;
        rsp.r  = result;
        rsp.z  = zero_flag;
        rsp.o  = overflow;
        rsp.u  = underflow;
        rsp.lt = less_than_flag;
        return rsp;
    endfunction

    task automatic check(input string name, input resp_t got, input resp_t want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got r=%08h z=%0b o=%0b u=%0b lt=%0b, want r=%08h z=%0b o=%0b u=%0b lt=%0b",
                     name, got.r, got.z, got.o, got.u, got.lt,
                     want.r, want.z, want.o, want.u, want.lt);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        txn_t t;
        @(negedge clk);
        ALUControl = op;
        a          = x;
        b          = y;
        t.op       = op;
        t.a        = x;
        t.b        = y;
        t.exp      = model(op, x, y);
        sb.push_back(t);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: the DUT presents a new response after every rising edge.
    initial begin
        txn_t t;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                t = sb.pop_front();
                n_txn++;
                check($sformatf("txn%0d_op%0h", n_txn, t.op), dut_resp(), t.exp);
                $display("txn %0d op=%h a=%08h b=%08h -> r=%08h z=%0b o=%0b u=%0b lt=%0b",
                         n_txn, t.op, t.a, t.b, result, zero_flag, overflow,
                         underflow, less_than_flag);
            end
        end
    end

    logic [3:0]  d_op [24] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                               4'h5, 4'h5, 4'h6, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1,
                               4'h7, 4'h8, 4'h9, 4'hF, 4'h7, 4'h9, 4'hA, 4'h8};
    logic [31:0] d_a  [24] = '{32'h40000000, 32'hFFFFFFF0, 32'h2, 32'h1,
                               32'hF0, 32'hF0, 32'hFF, 32'h4,
                               32'h1, 32'h80000000, 32'h80000000, 32'h80000000,
                               32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF,
                               32'h80000001, 32'h80000001, 32'h80000001, 32'h12345678,
                               32'hDEADBEEF, 32'h80000000, 32'hFFFFFFFF, 32'hF0000000};
    logic [31:0] d_b  [24] = '{32'h40000000, 32'h2, 32'h1, 32'hFFFFFFFF,
                               32'h0F, 32'h0F, 32'h0F, 32'h1,
                               32'h4, 32'h1, 32'h1, 32'h80000000,
                               32'h1, 32'h80000000, 32'h1, 32'hFFFFFFFF,
                               32'h21, 32'h21, 32'h21, 32'h5,
                               32'h0, 32'h1F, 32'hFFFFFFFF, 32'h24};

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        resp_t zero_rsp;
        resp_t mid_rsp;
        zero_rsp   = '0;
        reset      = 1'b1;
        ALUControl = 4'h0;
        a          = 32'h5;
        b          = 32'h7;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", dut_resp(), zero_rsp);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 24; i++) issue(d_op[i], d_a[i], d_b[i]);
        drain();

        // Asynchronous reset in mid-cycle clears a nonzero output at once;
        // the first edge after release loads the inputs still applied.
        @(negedge clk);
        ALUControl = 4'h3;
        a          = 32'hA5A50000;
        b          = 32'h00005A5A;
        @(posedge clk);
        #1;
        mid_rsp = model(4'h3, 32'hA5A50000, 32'h00005A5A);
        check("pre_reset_load", dut_resp(), mid_rsp);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_clear", dut_resp(), zero_rsp);
        @(negedge clk);
        reset = 1'b0;
        begin
            txn_t t;
            t.op  = 4'h3;
            t.a   = a;
            t.b   = b;
            t.exp = mid_rsp;
            sb.push_back(t);
        end
        drain();

        for (int i = 0; i < 300; i++) issue(4'($urandom_range(0, 15)), pick(), pick());
        drain();

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
